// File: rtl/syn_harness_io.sv
// -----------------------------------------------------------------------------
// syn_harness_io
//
// Purpose:
//   A serial-to-parallel and parallel-to-serial harness that sits between the
//   top-level pads and a unit under synthesis. A 1-bit pad stream is
//   deserialised into framed IN_WIDTH-bit words. The unit's OUT_WIDTH-bit
//   result is captured a fixed LATENCY cycles after each word is issued, and
//   that result is folded down to a single output bit. This lets a wide
//   datapath synthesise while using only a few pins.
//
// Parameters:
//   IN_WIDTH   word length towards the unit (>= 1)
//   OUT_WIDTH  result length from the unit (>= 1)
//   LATENCY    pipeline depth of the unit, from word_vld to result capture (>= 0)
//   CNT_WIDTH  width of the capture counter (>= 1)
//
// Ports:
//   clk       in   1          clock; all state changes on the rising edge
//   rst_n     in   1          asynchronous active-low reset; clears every register
//   bit_in    in   1          serial data, sampled when shift_en = 1
//   shift_en  in   1          shift enable
//   word_out  out  IN_WIDTH   framed word to the unit; holds between frames
//   word_vld  out  1          1-cycle strobe: word_out was just updated
//   word_in   in   OUT_WIDTH  result from the unit
//   bit_out   out  1          folded result bit; holds between folds
//   out_vld   out  1          1-cycle strobe: bit_out was just updated
//   cap_cnt   out  CNT_WIDTH  number of results folded, modulo 2^CNT_WIDTH
//
// Strobe semantics:
//   word_vld and out_vld are valid-only strobes with no ready/back-pressure.
//   Each one is high for exactly one cycle per new value, and the matching
//   data output is stable for as long as the strobe is high. A consumer must
//   take the data in that cycle.
//
// Build option:
//   SYN_HARNESS_MISR_EN
//     Undefined: the fold is the parity of the current result only.
//     Defined:   an OUT_WIDTH-bit signature register (cleared only by reset)
//                is rotated left by one and XORed with each result, and the
//                fold is the parity of the new signature.
//
// Timing:
//   If word_vld is high in cycle T, out_vld is high in cycle T + LATENCY + 2.
// -----------------------------------------------------------------------------
module syn_harness_io #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8,
  parameter int LATENCY   = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 shift_en,
  output logic [IN_WIDTH-1:0]  word_out,
  output logic                 word_vld,
  input  logic [OUT_WIDTH-1:0] word_in,
  output logic                 bit_out,
  output logic                 out_vld,
  output logic [CNT_WIDTH-1:0] cap_cnt
);

  localparam int BCNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(IN_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Deserialiser
  // ---------------------------------------------------------------------------
  // 'shifted' is the shift register value after taking in bit_in. Only the
  // low IN_WIDTH-1 bits of the shift register are ever read again, because the
  // MSB is shifted out at the same moment a frame completes. So only those
  // bits are stored. When IN_WIDTH is 1 there is nothing to store at all.
  logic [IN_WIDTH-1:0] shifted;

  if (IN_WIDTH == 1) begin : g_sh_none
    assign shifted = bit_in;
  end else begin : g_sh
    logic [IN_WIDTH-2:0] sh_q, sh_d;

    assign shifted = {sh_q, bit_in};
    assign sh_d    = shift_en ? shifted[IN_WIDTH-2:0] : sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh_q <= '0;
      else        sh_q <= sh_d;
    end
  end

  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [IN_WIDTH-1:0] word_q, word_d;
  logic                word_vld_q, word_vld_d;

  always_comb begin
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    if (shift_en) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d     = '0;
        word_d     = shifted;
        word_vld_d = 1'b1;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q     <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign word_out = word_q;
  assign word_vld = word_vld_q;

  // ---------------------------------------------------------------------------
  // Capture delay line: one register per pipeline stage of the unit. It is a
  // plain shift line, so back-to-back strobes each travel independently.
  // ---------------------------------------------------------------------------
  logic cap_en;

  if (LATENCY == 0) begin : g_dly_none
    assign cap_en = word_vld_q;
  end else begin : g_dly
    logic [LATENCY-1:0] dly_q, dly_d;
    logic [LATENCY:0]   dly_ext;

    assign dly_ext = {dly_q, word_vld_q};
    assign dly_d   = dly_ext[LATENCY-1:0];
    assign cap_en  = dly_q[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly_q <= '0;
      else        dly_q <= dly_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture and fold
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] cap_r_q, cap_r_d;
  logic                 cap_vld_q, cap_vld_d;
  logic                 bit_q, bit_d;
  logic                 out_vld_q, out_vld_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 fold_bit;

  assign cap_r_d   = cap_en ? word_in : cap_r_q;
  assign cap_vld_d = cap_en;

`ifdef SYN_HARNESS_MISR_EN
  logic [OUT_WIDTH-1:0] sig_q, sig_d, sig_rot, sig_next;

  if (OUT_WIDTH == 1) begin : g_rot_one
    assign sig_rot = sig_q;
  end else begin : g_rot
    assign sig_rot = {sig_q[OUT_WIDTH-2:0], sig_q[OUT_WIDTH-1]};
  end

  assign sig_next = sig_rot ^ cap_r_q;
  assign sig_d    = cap_vld_q ? sig_next : sig_q;
  assign fold_bit = ^sig_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end
`else
  assign fold_bit = ^cap_r_q;
`endif

  always_comb begin
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    out_vld_d = 1'b0;
    if (cap_vld_q) begin
      bit_d     = fold_bit;
      cnt_d     = cnt_q + CNT_WIDTH'(1);
      out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_r_q   <= '0;
      cap_vld_q <= 1'b0;
      bit_q     <= 1'b0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      cap_r_q   <= cap_r_d;
      cap_vld_q <= cap_vld_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bit_out = bit_q;
  assign out_vld = out_vld_q;
  assign cap_cnt = cnt_q;

endmodule

// File: tb/tb_syn_harness_io.sv
// -----------------------------------------------------------------------------
// tb_syn_harness_io
//
// Testbench for syn_harness_io, built with IN_WIDTH=4, OUT_WIDTH=8, LATENCY=2
// and CNT_WIDTH=2.
//
// The driver tasks shift in directed frames. For every frame they push the
// expected word and the expected {bit_out, cap_cnt} into queues. A monitor
// running on the falling clock edge pops and compares those entries whenever
// word_vld or out_vld is high. It also checks the latency from word_vld to
// out_vld, and checks that the outputs hold their values between strobes.
// -----------------------------------------------------------------------------
module tb_syn_harness_io;
  localparam int IW  = 4;
  localparam int OW  = 8;
  localparam int LAT = 2;
  localparam int CW  = 2;

  // Clock and reset
  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          bit_in   = 1'b0;
  logic          shift_en = 1'b0;
  logic [OW-1:0] word_in  = '0;
  logic [IW-1:0] word_out;
  logic          word_vld;
  logic          bit_out;
  logic          out_vld;
  logic [CW-1:0] cap_cnt;

  always #5 clk = ~clk;

  syn_harness_io #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .LATENCY  (LAT),
    .CNT_WIDTH(CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_in  (bit_in),
    .shift_en(shift_en),
    .word_out(word_out),
    .word_vld(word_vld),
    .word_in (word_in),
    .bit_out (bit_out),
    .out_vld (out_vld),
    .cap_cnt (cap_cnt)
  );

  // Scoreboard state
  int            n_vec  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  logic [IW-1:0] exp_word_q[$];
  logic [CW:0]   exp_out_q[$];   // {bit_out, cap_cnt}
  int            exp_time_q[$];
  logic [IW-1:0] word_hold = '0;
  logic          bit_hold  = 1'b0;
  logic [CW-1:0] cnt_hold  = '0;
  logic [CW-1:0] cnt_m     = '0;
  logic [OW-1:0] sig_m     = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [IW-1:0] w;
    logic [CW:0]   e;
    int            t;
    if (word_vld) begin
      if (exp_word_q.size() == 0) begin
        check("word_vld_unexpected", 32'(word_vld), 32'd0);
      end else begin
        w = exp_word_q.pop_front();
        word_hold = w;
        check("word_out", 32'(word_out), 32'(w));
        exp_time_q.push_back(cyc + LAT + 2);
      end
    end
    check("word_out_hold", 32'(word_out), 32'(word_hold));
    if (out_vld) begin
      if (exp_out_q.size() == 0 || exp_time_q.size() == 0) begin
        check("out_vld_unexpected", 32'(out_vld), 32'd0);
      end else begin
        e = exp_out_q.pop_front();
        t = exp_time_q.pop_front();
        bit_hold = e[CW];
        cnt_hold = e[CW-1:0];
        check("out_vld_latency", 32'(cyc), 32'(t));
        check("bit_out", 32'(bit_out), 32'(e[CW]));
        check("cap_cnt", 32'(cap_cnt), 32'(e[CW-1:0]));
      end
    end
    check("bit_out_hold", 32'(bit_out), 32'(bit_hold));
    check("cap_cnt_hold", 32'(cap_cnt), 32'(cnt_hold));
  end

  // Driver tasks; each returns 1 time unit after a rising edge
  task automatic do_reset();
    rst_n = 1'b0;
    exp_word_q.delete();
    exp_out_q.delete();
    exp_time_q.delete();
    word_hold = '0;
    bit_hold  = 1'b0;
    cnt_hold  = '0;
    cnt_m     = '0;
    sig_m     = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic shift_bit(input logic b);
    shift_en = 1'b1;
    bit_in   = b;
    @(posedge clk); #1;
    shift_en = 1'b0;
    bit_in   = 1'b0;
  endtask

  // exp_par is the hand-computed parity of res
  task automatic expect_frame(input logic [IW-1:0] w, input logic [OW-1:0] res, input logic exp_par);
    logic b;
    exp_word_q.push_back(w);
    cnt_m = cnt_m + 1'b1;
`ifdef SYN_HARNESS_MISR_EN
    sig_m = {sig_m[OW-2:0], sig_m[OW-1]} ^ res;
    b = ^sig_m;
`else
    b = exp_par;
`endif
    exp_out_q.push_back({b, cnt_m});
  endtask

  task automatic send_frame(input logic [IW-1:0] w, input logic [OW-1:0] res, input logic exp_par);
    for (int i = IW - 1; i >= 1; i--) shift_bit(w[i]);
    word_in = res;
    expect_frame(w, res, exp_par);
    shift_bit(w[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset values
    @(negedge clk);
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_word_vld", 32'(word_vld), 32'd0);
    check("rst_bit_out",  32'(bit_out),  32'd0);
    check("rst_out_vld",  32'(out_vld),  32'd0);
    check("rst_cap_cnt",  32'(cap_cnt),  32'd0);
    @(posedge clk); #1;

    // Consecutive shifts 1,0,1,1; result A5 has parity 0
    send_frame(4'b1011, 8'hA5, 1'b0);
    idle(6);

    // Shift 1,1, then a 3-cycle gap, then 0,1; result 07 has parity 1
    shift_bit(1'b1);
    shift_bit(1'b1);
    idle(3);
    shift_bit(1'b0);
    word_in = 8'h07;
    expect_frame(4'b1101, 8'h07, 1'b1);
    shift_bit(1'b1);
    idle(6);

    // A partial frame is discarded by reset
    shift_bit(1'b1);
    shift_bit(1'b1);
    do_reset();
    send_frame(4'b0010, 8'hFF, 1'b0);   // cnt 1

    // Back-to-back frames with cap_cnt wrapping 2,3,0
    send_frame(4'b0110, 8'h80, 1'b1);
    send_frame(4'b1001, 8'h3C, 1'b0);
    send_frame(4'b1111, 8'hFE, 1'b1);

    // Two captures of 01 (with the signature option: bit 1 then 0)
    send_frame(4'b0001, 8'h01, 1'b1);
    send_frame(4'b1000, 8'h01, 1'b1);
    idle(8);

    // Reset while a capture is still in flight: no out_vld may follow
    exp_word_q.push_back(4'b0101);
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b0);
    word_in = 8'h01;
    shift_bit(1'b1);
    idle(2);
    do_reset();
    idle(10);

    check("exp_word_q_drained", 32'(exp_word_q.size()), 32'd0);
    check("exp_out_q_drained",  32'(exp_out_q.size()),  32'd0);
    check("final_cap_cnt",      32'(cap_cnt),           32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
